edp_fm_slice: RTL and testbench

Fast-memory (AC block) register-file slice for one 6-bit EDP bit group (bits 30–35). It holds 8 blocks × 16 ACs. It is written from AR under CON control and returns registered read data to the ARM/ADA muxes of the same slice. It also stores a per-word partial parity bit for the 36-bit FM parity checker, flags slice parity mismatches, and supplies FM data to the EBUS diagnostic read path.

---
 rtl/edp_pkg.sv | 23 ++
 rtl/edp_fm_ram.sv | 30 +++
 rtl/edp_fm_slice.sv | 95 +++++++++
 tb/tb_edp_fm_slice.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/edp_pkg.sv
// Shared constants, types and helpers for the EDP fast-memory (AC block) slice.
package edp_pkg;

  localparam int SLICE_W = 6;
  localparam int BLOCKS  = 8;
  localparam int ACS     = 16;
  localparam int DEPTH   = BLOCKS * ACS;
  localparam int AW      = $clog2(DEPTH);

  typedef logic [AW-1:0]      fm_addr_t;
  typedef logic [SLICE_W-1:0] fm_word_t;

  typedef enum logic {
    FM_INIT,
    FM_RUN
  } fm_state_t;

  // Even partial parity; the 36-bit odd combine happens downstream.
  function automatic logic word_par(input fm_word_t w);
    return ^w;
  endfunction

endpackage

// File: rtl/edp_fm_ram.sv
// Plain FM storage: synchronous write, combinational read, one parity bit per word.
module edp_fm_ram
  import edp_pkg::*;
#(
  parameter int DATA_W = SLICE_W
) (
  input  logic              clk,
  input  logic              we,
  input  fm_addr_t          waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wpar,
  input  fm_addr_t          raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rpar
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              par [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
      par[waddr] <= wpar;
    end
  end

  assign rdata = mem[raddr];
  assign rpar  = par[raddr];

endmodule

// File: rtl/edp_fm_slice.sv
// FM register-file slice for EDP bits 30..35: clear sweep after reset, registered
// read with write-through bypass, stored partial parity and sticky mismatch flag.
module edp_fm_slice
  import edp_pkg::*;
(
  input  logic               clk_edp_h,
  input  logic               reset_l,
  input  logic [2:0]         apr_fm_block_h,
  input  logic [3:0]         apr_fm_adr_h,
  input  logic               con_fm_write_l,
  input  logic [SLICE_W-1:0] ar_h,
  input  logic               diag_fm_par_flip_h,
  input  logic               fm_par_err_clr_h,
  input  logic               diag_read_func_h,
  output logic [SLICE_W-1:0] fm_h,
  output logic               edp_fm_parity_h,
  output logic               fm_par_err_h,
  output logic               fm_init_busy_h,
  output logic [SLICE_W-1:0] ebus_d_h
);

  fm_state_t state;
  fm_addr_t  init_ctr;
  fm_addr_t  addr;
  logic      run;
  logic      wr_run;
  logic      wpar_new;
  logic      ram_we;
  fm_addr_t  ram_waddr;
  fm_word_t  ram_wdata;
  logic      ram_wpar;
  fm_word_t  rd_word;
  logic      rd_par;
  logic      chk_en;
  logic      mismatch;

  assign addr     = {apr_fm_block_h, apr_fm_adr_h};
  assign run      = (state == FM_RUN);
  assign wr_run   = run & ~con_fm_write_l;
  assign wpar_new = word_par(ar_h) ^ diag_fm_par_flip_h;

  // The clear sweep owns the write port until RUN; CON writes are dropped meanwhile.
  assign ram_we    = ~run | wr_run;
  assign ram_waddr = run ? addr : init_ctr;
  assign ram_wdata = run ? ar_h : '0;
  assign ram_wpar  = run & wpar_new;

  edp_fm_ram #(
    .DATA_W(SLICE_W)
  ) u_ram (
    .clk  (clk_edp_h),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .wpar (ram_wpar),
    .raddr(addr),
    .rdata(rd_word),
    .rpar (rd_par)
  );

  assign mismatch = (word_par(fm_h) != edp_fm_parity_h);

  always_ff @(posedge clk_edp_h or negedge reset_l) begin
    if (!reset_l) begin
      state           <= FM_INIT;
      init_ctr        <= '0;
      fm_h            <= '0;
      edp_fm_parity_h <= 1'b0;
      fm_par_err_h    <= 1'b0;
      fm_init_busy_h  <= 1'b1;
      chk_en          <= 1'b0;
    end else begin
      case (state)
        FM_INIT: begin
          init_ctr <= init_ctr + 1'b1;
          if (init_ctr == fm_addr_t'(DEPTH - 1)) begin
            state          <= FM_RUN;
            fm_init_busy_h <= 1'b0;
          end
        end
        FM_RUN: begin
          fm_h            <= wr_run ? ar_h : rd_word;
          edp_fm_parity_h <= wr_run ? wpar_new : rd_par;
          // chk_en delays checking until fm_h holds real read data; set beats clear.
          chk_en          <= 1'b1;
          fm_par_err_h    <= (chk_en & mismatch) | (fm_par_err_h & ~fm_par_err_clr_h);
        end
        default: state <= FM_INIT;
      endcase
    end
  end

  assign ebus_d_h = diag_read_func_h ? fm_h : '0;

endmodule

// File: tb/tb_edp_fm_slice.sv
// Bench for edp_fm_slice: directed vector table, reset/INIT corner sequences and
// randomized traffic checked against a word-level memory model.
module tb_edp_fm_slice;
  import edp_pkg::*;

  logic       clk = 1'b0;
  logic       reset_l = 1'b0;
  logic [2:0] blk = '0;
  logic [3:0] acn = '0;
  logic       wr_l = 1'b1;
  logic [5:0] ar = '0;
  logic       flip = 1'b0;
  logic       clr = 1'b0;
  logic       diag = 1'b0;
  logic [5:0] fm;
  logic       fpar;
  logic       perr;
  logic       busy;
  logic [5:0] ebus;

  always #5 clk = ~clk;

  edp_fm_slice dut (
    .clk_edp_h         (clk),
    .reset_l           (reset_l),
    .apr_fm_block_h    (blk),
    .apr_fm_adr_h      (acn),
    .con_fm_write_l    (wr_l),
    .ar_h              (ar),
    .diag_fm_par_flip_h(flip),
    .fm_par_err_clr_h  (clr),
    .diag_read_func_h  (diag),
    .fm_h              (fm),
    .edp_fm_parity_h   (fpar),
    .fm_par_err_h      (perr),
    .fm_init_busy_h    (busy),
    .ebus_d_h          (ebus)
  );

  int n_tot = 0;
  int n_pass = 0;

  // Reference model: word-level memory, busy countdown, output registers.
  logic [5:0] m_mem [128];
  logic       m_pbit [128];
  int         m_busy;
  logic [5:0] m_fm;
  logic       m_par;
  logic       m_err;
  logic       m_chk;

  typedef struct {
    bit         we;
    logic [6:0] a;
    logic [5:0] d;
    bit         flip;
    bit         clr;
    logic [5:0] exp_fm;
    bit         exp_par;
    bit         exp_err;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) begin
      m_mem[i]  = '0;
      m_pbit[i] = 1'b0;
    end
    m_busy = 128;
    m_fm   = '0;
    m_par  = 1'b0;
    m_err  = 1'b0;
    m_chk  = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".fm"},   fm,   m_fm);
    chk({tag, ".par"},  fpar, m_par);
    chk({tag, ".err"},  perr, m_err);
    chk({tag, ".busy"}, busy, (m_busy > 0));
    chk({tag, ".ebus"}, ebus, diag ? m_fm : 6'd0);
  endtask

  task automatic step(input bit we, input logic [6:0] a, input logic [5:0] d,
                      input bit fl, input bit cl, input bit dg, input string tag);
    logic       p;
    logic [5:0] rd;
    logic       rp;
    logic       en;
    blk  = a[6:4];
    acn  = a[3:0];
    wr_l = ~we;
    ar   = d;
    flip = fl;
    clr  = cl;
    diag = dg;
    @(posedge clk);
    if (m_busy > 0) begin
      m_busy--;
    end else begin
      p  = (^d) ^ fl;
      rd = we ? d : m_mem[a];
      rp = we ? p : m_pbit[a];
      en = (m_chk && ((^m_fm) != m_par)) || (m_err && !cl);
      if (we) begin
        m_mem[a]  = d;
        m_pbit[a] = p;
      end
      m_fm  = rd;
      m_par = rp;
      m_err = en;
      m_chk = 1'b1;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_l = 1'b0;
    #1;
    model_reset();
    check_outputs("rst");
    @(negedge clk);
    reset_l = 1'b1;
  endtask

  task automatic async_reset_check(input string tag);
    #2;
    reset_l = 1'b0;
    #1;
    chk({tag, ".fm0"},   fm,   6'd0);
    chk({tag, ".par0"},  fpar, 1'b0);
    chk({tag, ".err0"},  perr, 1'b0);
    chk({tag, ".busy1"}, busy, 1'b1);
    chk({tag, ".ebus0"}, ebus, 6'd0);
    model_reset();
    @(negedge clk);
    reset_l = 1'b1;
  endtask

  task automatic busy_length(input string tag);
    int cnt;
    cnt = 0;
    while (busy && cnt < 200) begin
      step(0, 7'h00, 6'o00, 0, 0, 0, tag);
      cnt++;
    end
    chk({tag, ".busy_len"}, cnt, 128);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //         we  addr   data   flip clr  exp_fm exp_par exp_err
    tbl[0]  = '{1, 7'h35, 6'o52, 0, 0, 6'o52, 1, 0};
    tbl[1]  = '{0, 7'h35, 6'o00, 0, 0, 6'o52, 1, 0};
    tbl[2]  = '{0, 7'h34, 6'o00, 0, 0, 6'o00, 0, 0};
    tbl[3]  = '{1, 7'h7F, 6'o77, 0, 0, 6'o77, 0, 0};
    tbl[4]  = '{0, 7'h7F, 6'o00, 0, 0, 6'o77, 0, 0};
    tbl[5]  = '{1, 7'h10, 6'o01, 1, 0, 6'o01, 0, 0};
    tbl[6]  = '{0, 7'h10, 6'o00, 0, 0, 6'o01, 0, 1};
    tbl[7]  = '{0, 7'h35, 6'o00, 0, 0, 6'o52, 1, 1};
    tbl[8]  = '{0, 7'h34, 6'o00, 0, 0, 6'o00, 0, 1};
    tbl[9]  = '{0, 7'h34, 6'o00, 0, 1, 6'o00, 0, 0};
    tbl[10] = '{0, 7'h10, 6'o00, 0, 0, 6'o01, 0, 0};
    tbl[11] = '{0, 7'h34, 6'o00, 0, 1, 6'o00, 0, 1};
    tbl[12] = '{0, 7'h34, 6'o00, 0, 1, 6'o00, 0, 0};

    model_reset();

    // Power-up sweep and all-zero readback.
    apply_reset();
    busy_length("init");
    for (int a = 0; a < 128; a++) begin
      step(0, 7'(a), 6'o00, 0, 0, 1, "rd0");
      chk("rd0.zero", fm, 6'd0);
    end

    // Directed writes, bypass, parity injection and sticky clear.
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].flip, tbl[i].clr, i[0], "tbl");
      chk($sformatf("tbl%0d.fm", i),  fm,   tbl[i].exp_fm);
      chk($sformatf("tbl%0d.par", i), fpar, tbl[i].exp_par);
      chk($sformatf("tbl%0d.err", i), perr, tbl[i].exp_err);
    end

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [6:0] a;
      a = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 7)) : 7'($urandom_range(0, 127));
      step(($urandom_range(0, 2) == 0), a, 6'($urandom), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1, "rnd");
    end

    // Write during INIT is dropped.
    apply_reset();
    for (int c = 1; c <= 128; c++) begin
      if (c == 10) step(1, 7'h00, 6'o17, 0, 0, 1, "iw");
      else         step(0, 7'h00, 6'o00, 0, 0, 1, "iw");
    end
    chk("iw.busy_done", busy, 1'b0);
    step(0, 7'h00, 6'o00, 0, 0, 1, "iw");
    chk("iw.dropped", fm, 6'd0);

    // Reset mid-INIT restarts the sweep.
    apply_reset();
    for (int c = 0; c < 60; c++) step(0, 7'h05, 6'o00, 0, 0, 1, "mi");
    async_reset_check("mid_init");
    busy_length("mid_init");

    // Reset mid-RUN with nonzero output and error flag set.
    step(1, 7'h22, 6'o01, 1, 0, 1, "mr");
    step(0, 7'h22, 6'o00, 0, 0, 1, "mr");
    chk("mr.err_set", perr, 1'b1);
    chk("mr.ebus_on", ebus, 6'o01);
    step(0, 7'h22, 6'o00, 0, 0, 0, "mr");
    chk("mr.ebus_off", ebus, 6'd0);
    async_reset_check("mid_run");
    busy_length("mid_run");
    step(0, 7'h22, 6'o00, 0, 0, 1, "mr");
    chk("mr.cleared", fm, 6'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
